// File: rtl/ashr16_iter.sv
// Iterative 16-bit arithmetic right shifter. Each SHIFT cycle applies a by-4 or by-1 step until the count is exhausted.
// Optional macro ASHR16_LOGICAL_EN adds a 'logical' input that selects zero fill instead of sign fill.
module ashr16_iter #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
`ifdef ASHR16_LOGICAL_EN
  input  logic             logical,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataout
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill;

`ifdef ASHR16_LOGICAL_EN
  logic logical_q, logical_d;
  assign fill = ~logical_q & data_q[WIDTH-1];
`else
  assign fill = data_q[WIDTH-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef ASHR16_LOGICAL_EN
      logical_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef ASHR16_LOGICAL_EN
      logical_q <= logical_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef ASHR16_LOGICAL_EN
    logical_d = logical_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = a;
          cnt_d   = shamt;
`ifdef ASHR16_LOGICAL_EN
          logical_d = logical;
`endif
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Coarse steps first, then single-bit steps for the remainder.
        if (cnt_q >= SHW'(4)) begin
          data_d = {{4{fill}}, data_q[WIDTH-1:4]};
          cnt_d  = cnt_q - SHW'(4);
        end else begin
          data_d = {fill, data_q[WIDTH-1:1]};
          cnt_d  = cnt_q - SHW'(1);
        end
        if (cnt_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign dataout = data_q;

endmodule

// File: tb/tb_ashr16_iter.sv
// Bench for ashr16_iter: latency/result model checked every cycle plus hand-computed directed checks.
module tb_ashr16_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0;
  logic [3:0]  shamt = 4'h0;
  logic        busy, done;
  logic [15:0] dataout;
`ifdef ASHR16_LOGICAL_EN
  logic        logical = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  ashr16_iter dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .shamt(shamt),
`ifdef ASHR16_LOGICAL_EN
    .logical(logical),
`endif
    .busy(busy), .done(done), .dataout(dataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference shift: sign or zero fill by n bits.
  function automatic logic [15:0] shr(input logic [15:0] v, input int n, input logic lg);
    logic signed [15:0] s;
    s = v;
    if (lg) return v >> n;
    return s >>> n;
  endfunction

  // Model: after n steps of a k-step operation the total shift is 4*min(n,q) plus the extra single steps.
  int          m_phase = 0;  // 0 idle, 1 busy, 2 done
  int          m_n = 0, m_k = 0, m_sh = 0;
  logic [15:0] m_a = '0, m_out = '0;
  logic        m_lg = 1'b0;

  function automatic int shifted(input int n, input int sh);
    int q;
    q = sh / 4;
    return (n <= q) ? 4 * n : 4 * q + (n - q);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_out   <= '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_a   <= a;
          m_sh  <= int'(shamt);
          m_k   <= int'(shamt) / 4 + int'(shamt) % 4;
          m_n   <= 0;
          m_out <= a;
`ifdef ASHR16_LOGICAL_EN
          m_lg  <= logical;
`else
          m_lg  <= 1'b0;
`endif
          m_phase <= (shamt == 4'd0) ? 2 : 1;
        end
        1: begin
          m_n   <= m_n + 1;
          m_out <= shr(m_a, shifted(m_n + 1, m_sh), m_lg);
          if (m_n + 1 == m_k) m_phase <= 2;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("model_busy", {15'b0, busy}, {15'b0, m_phase == 1});
    chk("model_done", {15'b0, done}, {15'b0, m_phase == 2});
    chk("model_dataout", dataout, m_out);
  end

  task automatic issue(input logic [15:0] av, input logic [3:0] sv);
    @(negedge clk);
    start = 1'b1; a = av; shamt = sv;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; shamt = 4'h7;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    chk("pin_model_8000_5", shr(16'h8000, 5, 1'b0), 16'hFC00);
    chk("pin_model_8001_15", shr(16'h8001, 15, 1'b0), 16'hFFFF);
    chk("pin_model_shifted_15", 16'(shifted(6, 15)), 16'd15);

    cyc(3);
    chk("reset_busy", {15'b0, busy}, 16'h0);
    chk("reset_done", {15'b0, done}, 16'h0);
    chk("reset_dataout", dataout, 16'h0000);
    reset = 1'b0;
    cyc(1);

    issue(16'h8000, 4'd5);                       // now in T+1
    chk("t1_busy_T1", {15'b0, busy}, 16'h1);
    cyc(1); chk("t1_step1", dataout, 16'hF800);
    cyc(1); chk("t1_done", {15'b0, done}, 16'h1); chk("t1_result", dataout, 16'hFC00);
    cyc(1); chk("t1_done_pulse", {15'b0, done}, 16'h0); chk("t1_hold", dataout, 16'hFC00);

    issue(16'h1234, 4'd0);
    chk("t2_nobusy", {15'b0, busy}, 16'h0);
    chk("t2_done", {15'b0, done}, 16'h1); chk("t2_result", dataout, 16'h1234);
    cyc(1); chk("t2_idle", {15'b0, done | busy}, 16'h0);

    issue(16'h7FFF, 4'd15);
    cyc(5); chk("t3_busy_T6", {15'b0, busy}, 16'h1);
    cyc(1); chk("t3_done_T7", {15'b0, done}, 16'h1); chk("t3_result", dataout, 16'h0000);

    issue(16'h8001, 4'd15);
    cyc(6); chk("t4_done_T7", {15'b0, done}, 16'h1); chk("t4_result", dataout, 16'hFFFF);

    // A start while busy must be ignored entirely.
    @(negedge clk); start = 1'b1; a = 16'hF0F0; shamt = 4'd8;
    @(negedge clk); start = 1'b1; a = 16'h0001; shamt = 4'd1;
    @(negedge clk); start = 1'b0;
    chk("t5_busy_T2", {15'b0, busy}, 16'h1);
    cyc(1); chk("t5_done_T3", {15'b0, done}, 16'h1); chk("t5_result", dataout, 16'hFFF0);
    cyc(1); chk("t5_hold", dataout, 16'hFFF0);

    issue(16'hF0F0, 4'd8);
    reset = 1'b1;
    cyc(1);
    chk("t6_busy", {15'b0, busy}, 16'h0);
    chk("t6_dataout", dataout, 16'h0000);
    chk("t6_done", {15'b0, done}, 16'h0);
    reset = 1'b0;
    cyc(3); chk("t6_no_done", {15'b0, done}, 16'h0);

    // Sweep every shift amount with a mixed-sign pattern; the per-cycle model does the checking.
    for (int s = 0; s < 16; s++) begin
      issue((s % 2 == 0) ? 16'h9ABC : 16'h5A3C, 4'(s));
      cyc(s / 4 + s % 4 + 1);
    end

`ifdef ASHR16_LOGICAL_EN
    @(negedge clk); start = 1'b1; a = 16'h8000; shamt = 4'd5; logical = 1'b1;
    @(negedge clk); start = 1'b0; logical = 1'b0;
    cyc(2); chk("t7_logical_done", {15'b0, done}, 16'h1); chk("t7_logical_result", dataout, 16'h0400);
`endif

    cyc(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
